// File: rtl/fault_monitor_pkg.sv
// Shared types for the fault safety monitor: FSM state and violation cause codes.
package fault_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RECOVERING = 2'd1,
        TIMED_OUT  = 2'd2
    } mon_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_WRITE    = 3'd1,
        CAUSE_TIMEOUT  = 3'd2,
        CAUSE_EARLY    = 3'd3,
        CAUSE_SPURIOUS = 3'd4
    } viol_cause_t;

endpackage

// File: rtl/recovery_window_fsm.sv
// Tracks each recover_cpu pulse and checks that resume_cpu lands inside
// [MIN_RESUME, RESUME_TIMEOUT] cycles after it. Event strobes are
// combinational so the top can register them in the same cycle.
module recovery_window_fsm
    import fault_monitor_pkg::*;
#(
    parameter int unsigned MIN_RESUME     = 1,
    parameter int unsigned RESUME_TIMEOUT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       recover_cpu,
    input  logic       resume_cpu,
    output logic       ev_timeout_c,
    output logic       ev_early_c,
    output logic       ev_spurious_c,
    output logic [1:0] mon_state
);

    localparam int unsigned TW = $clog2(RESUME_TIMEOUT + 1);
    localparam logic [TW-1:0] MIN_T = TW'(MIN_RESUME);
    localparam logic [TW-1:0] MAX_T = TW'(RESUME_TIMEOUT);

    mon_state_t    state;
    logic [TW-1:0] timer;

    assign mon_state = state;

    // State and timer; timer counts cycles since the latest recover pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (recover_cpu && !resume_cpu) begin
                        state <= RECOVERING;
                        timer <= TW'(1);
                    end
                end
                RECOVERING: begin
                    if (recover_cpu) begin
                        timer <= TW'(1);
                    end else if (resume_cpu) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == MAX_T) begin
                        state <= TIMED_OUT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                TIMED_OUT: begin
                    if (resume_cpu) begin
                        state <= IDLE;
                    end else if (recover_cpu) begin
                        state <= RECOVERING;
                        timer <= TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Violation strobes decoded from the current state, timer and pulses.
    always_comb begin
        ev_timeout_c  = 1'b0;
        ev_early_c    = 1'b0;
        ev_spurious_c = 1'b0;
        case (state)
            IDLE: begin
                ev_early_c    = recover_cpu && resume_cpu;
                ev_spurious_c = resume_cpu && !recover_cpu;
            end
            RECOVERING: begin
                ev_early_c   = !recover_cpu && resume_cpu && (timer < MIN_T);
                ev_timeout_c = !recover_cpu && !resume_cpu && (timer == MAX_T);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fault_safety_monitor.sv
// Run-time safety monitor: write-during-safe-mode check plus recovery window
// check, reported as sticky flags, saturating counter, alarm and first cause.
module fault_safety_monitor
    import fault_monitor_pkg::*;
#(
    parameter int unsigned NUM_WR_CH      = 3,
    parameter int unsigned MIN_RESUME     = 1,
    parameter int unsigned RESUME_TIMEOUT = 10,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 safe_mode,
    input  logic [NUM_WR_CH-1:0] wr_en,
    input  logic                 recover_cpu,
    input  logic                 resume_cpu,
    input  logic                 clear_flags,
    output logic [NUM_WR_CH-1:0] viol_write,
    output logic                 viol_timeout,
    output logic                 viol_early,
    output logic                 viol_spurious,
    output logic [CNT_W-1:0]     viol_count,
    output logic                 alarm,
    output logic [2:0]           first_cause,
    output logic [1:0]           mon_state
);

    // Reject parameter sets that make the resume window meaningless.
    generate
        if (MIN_RESUME < 1 || RESUME_TIMEOUT < MIN_RESUME || NUM_WR_CH < 1 || CNT_W < 1) begin : g_bad_params
            $error("fault_safety_monitor: illegal parameters");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 ev_timeout_c;
    logic                 ev_early_c;
    logic                 ev_spurious_c;
    logic [NUM_WR_CH-1:0] wr_hit_c;
    logic                 ev_write_c;
    logic                 any_ev_c;
    viol_cause_t          cause_c;

    recovery_window_fsm #(
        .MIN_RESUME    (MIN_RESUME),
        .RESUME_TIMEOUT(RESUME_TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .recover_cpu  (recover_cpu),
        .resume_cpu   (resume_cpu),
        .ev_timeout_c (ev_timeout_c),
        .ev_early_c   (ev_early_c),
        .ev_spurious_c(ev_spurious_c),
        .mon_state    (mon_state)
    );

    // Per-cycle event decode with write > timeout > early > spurious priority.
    always_comb begin
        wr_hit_c   = safe_mode ? wr_en : '0;
        ev_write_c = |wr_hit_c;
        any_ev_c   = ev_write_c || ev_timeout_c || ev_early_c || ev_spurious_c;
        cause_c    = CAUSE_NONE;
        if (ev_write_c)         cause_c = CAUSE_WRITE;
        else if (ev_timeout_c)  cause_c = CAUSE_TIMEOUT;
        else if (ev_early_c)    cause_c = CAUSE_EARLY;
        else if (ev_spurious_c) cause_c = CAUSE_SPURIOUS;
    end

    // Sticky flags, counter and first cause; a same-cycle event beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            viol_write    <= '0;
            viol_timeout  <= 1'b0;
            viol_early    <= 1'b0;
            viol_spurious <= 1'b0;
            viol_count    <= '0;
            alarm         <= 1'b0;
            first_cause   <= 3'd0;
        end else begin
            alarm <= any_ev_c;
            if (clear_flags) begin
                viol_write    <= wr_hit_c;
                viol_timeout  <= ev_timeout_c;
                viol_early    <= ev_early_c;
                viol_spurious <= ev_spurious_c;
                viol_count    <= any_ev_c ? CNT_W'(1) : '0;
                first_cause   <= 3'(cause_c);
            end else begin
                viol_write    <= viol_write | wr_hit_c;
                viol_timeout  <= viol_timeout | ev_timeout_c;
                viol_early    <= viol_early | ev_early_c;
                viol_spurious <= viol_spurious | ev_spurious_c;
                if (any_ev_c && viol_count != CNT_MAX) begin
                    viol_count <= viol_count + CNT_W'(1);
                end
                if (first_cause == 3'd0) begin
                    first_cause <= 3'(cause_c);
                end
            end
        end
    end

endmodule

// File: tb/tb_fault_safety_monitor.sv
// Directed bench for fault_safety_monitor: default instance plus a
// MIN_RESUME=3 instance and a CNT_W=2 instance sharing one stimulus set.
module tb_fault_safety_monitor;

    logic       clk;
    logic       reset;
    logic       safe_mode;
    logic [2:0] wr_en;
    logic       recover_cpu;
    logic       resume_cpu;
    logic       clear_flags;

    logic [2:0] a_vw, e_vw, s_vw;
    logic       a_vt, e_vt, s_vt;
    logic       a_ve, e_ve, s_ve;
    logic       a_vs, e_vs, s_vs;
    logic [7:0] a_cnt, e_cnt;
    logic [1:0] s_cnt;
    logic       a_al, e_al, s_al;
    logic [2:0] a_fc, e_fc, s_fc;
    logic [1:0] a_st, e_st, s_st;

    int total = 0;
    int bad   = 0;

    fault_safety_monitor dut_a (
        .clk(clk), .reset(reset), .safe_mode(safe_mode), .wr_en(wr_en),
        .recover_cpu(recover_cpu), .resume_cpu(resume_cpu), .clear_flags(clear_flags),
        .viol_write(a_vw), .viol_timeout(a_vt), .viol_early(a_ve), .viol_spurious(a_vs),
        .viol_count(a_cnt), .alarm(a_al), .first_cause(a_fc), .mon_state(a_st)
    );

    fault_safety_monitor #(.MIN_RESUME(3)) dut_e (
        .clk(clk), .reset(reset), .safe_mode(safe_mode), .wr_en(wr_en),
        .recover_cpu(recover_cpu), .resume_cpu(resume_cpu), .clear_flags(clear_flags),
        .viol_write(e_vw), .viol_timeout(e_vt), .viol_early(e_ve), .viol_spurious(e_vs),
        .viol_count(e_cnt), .alarm(e_al), .first_cause(e_fc), .mon_state(e_st)
    );

    fault_safety_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .safe_mode(safe_mode), .wr_en(wr_en),
        .recover_cpu(recover_cpu), .resume_cpu(resume_cpu), .clear_flags(clear_flags),
        .viol_write(s_vw), .viol_timeout(s_vt), .viol_early(s_ve), .viol_spurious(s_vs),
        .viol_count(s_cnt), .alarm(s_al), .first_cause(s_fc), .mon_state(s_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        safe_mode = 1'b0; wr_en = 3'b000; recover_cpu = 1'b0;
        resume_cpu = 1'b0; clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_vw !== 3'b000) begin bad++; $display("FAIL reset_vw got=%b exp=000", a_vw); end
        total++; if ({a_vt, a_ve, a_vs, a_al} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {a_vt, a_ve, a_vs, a_al}); end
        total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
        total++; if (a_fc !== 3'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", a_fc); end
        total++; if (a_st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", a_st); end
    endtask

    task automatic test_write();
        do_reset();
        safe_mode = 1'b0; wr_en = 3'b111;
        step();
        total++; if (a_vw !== 3'b000 || a_al !== 1'b0) begin bad++; $display("FAIL write_no_safe got=%b/%b exp=000/0", a_vw, a_al); end
        safe_mode = 1'b1; wr_en = 3'b100;
        step();
        idle_inputs();
        total++; if (a_vw !== 3'b100) begin bad++; $display("FAIL write_flag got=%b exp=100", a_vw); end
        total++; if (a_al !== 1'b1) begin bad++; $display("FAIL write_alarm got=%b exp=1", a_al); end
        total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL write_cnt got=%0d exp=1", a_cnt); end
        total++; if (a_fc !== 3'd1) begin bad++; $display("FAIL write_fc got=%0d exp=1", a_fc); end
        step();
        total++; if (a_al !== 1'b0 || a_vw !== 3'b100) begin bad++; $display("FAIL write_sticky got=%b/%b exp=0/100", a_al, a_vw); end
        safe_mode = 1'b1; wr_en = 3'b011;
        step();
        idle_inputs();
        total++; if (a_vw !== 3'b111 || a_cnt !== 8'd2) begin bad++; $display("FAIL write_multi got=%b/%0d exp=111/2", a_vw, a_cnt); end
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        total++; if (a_vw !== 3'b000 || a_cnt !== 8'd0 || a_fc !== 3'd0) begin bad++; $display("FAIL write_clear got=%b/%0d/%0d exp=000/0/0", a_vw, a_cnt, a_fc); end
    endtask

    task automatic test_good_resume();
        do_reset();
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            total++; if (a_st !== 2'd1) begin bad++; $display("FAIL good_state_t%0d got=%0d exp=1", k, a_st); end
            step();
        end
        total++; if (a_st !== 2'd1) begin bad++; $display("FAIL good_state_t10 got=%0d exp=1", a_st); end
        resume_cpu = 1'b1;
        step();
        resume_cpu = 1'b0;
        total++; if (a_st !== 2'd0) begin bad++; $display("FAIL good_state_t11 got=%0d exp=0", a_st); end
        total++; if ({a_vt, a_ve, a_vs, a_al} !== 4'b0000 || a_cnt !== 8'd0) begin bad++; $display("FAIL good_noflags got=%b/%0d exp=0000/0", {a_vt, a_ve, a_vs, a_al}, a_cnt); end
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0; resume_cpu = 1'b1;
        step();
        resume_cpu = 1'b0;
        total++; if (a_ve !== 1'b0 || a_st !== 2'd0 || a_cnt !== 8'd0) begin bad++; $display("FAIL good_min_bound got=%b/%0d/%0d exp=0/0/0", a_ve, a_st, a_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        step(9);
        total++; if (a_vt !== 1'b0 || a_st !== 2'd1) begin bad++; $display("FAIL tmo_before got=%b/%0d exp=0/1", a_vt, a_st); end
        step();
        total++; if (a_vt !== 1'b1 || a_st !== 2'd2) begin bad++; $display("FAIL tmo_flag got=%b/%0d exp=1/2", a_vt, a_st); end
        total++; if (a_cnt !== 8'd1 || a_fc !== 3'd2 || a_al !== 1'b1) begin bad++; $display("FAIL tmo_report got=%0d/%0d/%b exp=1/2/1", a_cnt, a_fc, a_al); end
        step(4);
        total++; if (a_st !== 2'd2 || a_cnt !== 8'd1 || a_al !== 1'b0) begin bad++; $display("FAIL tmo_hold got=%0d/%0d/%b exp=2/1/0", a_st, a_cnt, a_al); end
        resume_cpu = 1'b1;
        step();
        resume_cpu = 1'b0;
        total++; if (a_st !== 2'd0 || a_cnt !== 8'd1 || a_vs !== 1'b0) begin bad++; $display("FAIL tmo_late_resume got=%0d/%0d/%b exp=0/1/0", a_st, a_cnt, a_vs); end
    endtask

    task automatic test_spurious_early();
        do_reset();
        resume_cpu = 1'b1;
        step();
        resume_cpu = 1'b0;
        total++; if (a_vs !== 1'b1 || a_fc !== 3'd4 || a_cnt !== 8'd1) begin bad++; $display("FAIL spurious got=%b/%0d/%0d exp=1/4/1", a_vs, a_fc, a_cnt); end
        do_reset();
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        step();
        resume_cpu = 1'b1;
        step();
        resume_cpu = 1'b0;
        total++; if (e_ve !== 1'b1 || e_fc !== 3'd3 || e_st !== 2'd0) begin bad++; $display("FAIL early_min3 got=%b/%0d/%0d exp=1/3/0", e_ve, e_fc, e_st); end
        total++; if (a_ve !== 1'b0 || a_st !== 2'd0) begin bad++; $display("FAIL early_min1_legal got=%b/%0d exp=0/0", a_ve, a_st); end
        do_reset();
        recover_cpu = 1'b1; resume_cpu = 1'b1;
        step();
        idle_inputs();
        total++; if (a_ve !== 1'b1 || a_vs !== 1'b0 || a_st !== 2'd0) begin bad++; $display("FAIL early_same_cycle got=%b/%b/%0d exp=1/0/0", a_ve, a_vs, a_st); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        step(9);
        safe_mode = 1'b1; wr_en = 3'b001;
        step();
        idle_inputs();
        total++; if (a_vw !== 3'b001 || a_vt !== 1'b1) begin bad++; $display("FAIL same_flags got=%b/%b exp=001/1", a_vw, a_vt); end
        total++; if (a_cnt !== 8'd1 || a_fc !== 3'd1) begin bad++; $display("FAIL same_cnt_fc got=%0d/%0d exp=1/1", a_cnt, a_fc); end
        safe_mode = 1'b1; wr_en = 3'b010; clear_flags = 1'b1;
        step();
        idle_inputs();
        total++; if (a_vw !== 3'b010 || a_vt !== 1'b0) begin bad++; $display("FAIL clear_vs_event got=%b/%b exp=010/0", a_vw, a_vt); end
        total++; if (a_cnt !== 8'd1 || a_fc !== 3'd1 || a_al !== 1'b1) begin bad++; $display("FAIL clear_event_cnt got=%0d/%0d/%b exp=1/1/1", a_cnt, a_fc, a_al); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        step(7);
        recover_cpu = 1'b1; resume_cpu = 1'b1;
        step();
        idle_inputs();
        total++; if (a_st !== 2'd1 || a_al !== 1'b0) begin bad++; $display("FAIL rearm_state got=%0d/%b exp=1/0", a_st, a_al); end
        step(9);
        total++; if (a_vt !== 1'b0) begin bad++; $display("FAIL rearm_no_early_tmo got=%b exp=0", a_vt); end
        step();
        total++; if (a_vt !== 1'b1 || a_st !== 2'd2) begin bad++; $display("FAIL rearm_tmo got=%b/%0d exp=1/2", a_vt, a_st); end
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        total++; if (a_st !== 2'd1 || a_cnt !== 8'd1) begin bad++; $display("FAIL tmo_rerecover got=%0d/%0d exp=1/1", a_st, a_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        resume_cpu = 1'b1;
        step(3);
        total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_reach got=%0d exp=3", s_cnt); end
        step(2);
        resume_cpu = 1'b0;
        total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d exp=3", s_cnt); end
        total++; if (a_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide got=%0d exp=5", a_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        recover_cpu = 1'b1;
        step();
        recover_cpu = 1'b0;
        step(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (a_st !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", a_st); end
        step(12);
        total++; if (a_vt !== 1'b0 || a_cnt !== 8'd0 || a_st !== 2'd0) begin bad++; $display("FAIL rstmid_no_tmo got=%b/%0d/%0d exp=0/0/0", a_vt, a_cnt, a_st); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_good_resume();
        test_timeout();
        test_spurious_early();
        test_same_cycle();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
